// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the SAP-U 8-bit computer.
// Build option: define SEQ_EARLY_RESET_EN to end each instruction after its last non-idle microstep.
module control_sequencer #(
    parameter int STEPS = 5
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        carry,
    input  logic        zero,
    output logic [15:0] ctrl_word,
    output logic [2:0]  step,
    output logic        halted
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    // Each mask marks one signal in its asserted sense; IDLE ^ mask yields the real pin levels,
    // because active-low bits idle high and active-high bits idle low.
    localparam logic [15:0] IDLE = 16'h7FB7;
    localparam logic [15:0] HLT  = 16'h8000;
    localparam logic [15:0] MI   = 16'h4000;
    localparam logic [15:0] RI   = 16'h2000;
    localparam logic [15:0] RO   = 16'h1000;
    localparam logic [15:0] IO   = 16'h0800;
    localparam logic [15:0] II   = 16'h0400;
    localparam logic [15:0] AI   = 16'h0200;
    localparam logic [15:0] AO   = 16'h0100;
    localparam logic [15:0] EO   = 16'h0080;
    localparam logic [15:0] SU   = 16'h0040;
    localparam logic [15:0] BI   = 16'h0020;
    localparam logic [15:0] OI   = 16'h0010;
    localparam logic [15:0] CE   = 16'h0008;
    localparam logic [15:0] CO   = 16'h0004;
    localparam logic [15:0] J    = 16'h0002;
    localparam logic [15:0] FI   = 16'h0001;

    opcode_t     op;
    logic [15:0] active;
    logic [2:0]  last_step;

    assign op = opcode_t'(opcode);

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        active = 16'h0000;
        case (step)
            3'd0: active = CO | MI;
            3'd1: active = RO | II | CE;
            3'd2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: active = IO | MI;
                    OP_LDI:  active = IO | AI;
                    OP_JMP:  active = IO | J;
                    OP_JC:   active = carry ? (IO | J) : 16'h0000;
                    OP_JZ:   active = zero  ? (IO | J) : 16'h0000;
                    OP_OUT:  active = AO | OI;
                    OP_HLT:  active = HLT;
                    default: active = 16'h0000;
                endcase
            end
            3'd3: begin
                case (op)
                    OP_LDA:         active = RO | AI;
                    OP_ADD, OP_SUB: active = RO | BI;
                    OP_STA:         active = AO | RI;
                    default:        active = 16'h0000;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_ADD:  active = EO | AI | FI;
                    OP_SUB:  active = EO | AI | FI | SU;
                    default: active = 16'h0000;
                endcase
            end
            default: active = 16'h0000;
        endcase
    end

    // Microstep after which the counter returns to T0 (HLT is caught before this applies).
    always_comb begin
`ifdef SEQ_EARLY_RESET_EN
        case (op)
            OP_ADD, OP_SUB: last_step = 3'(STEPS - 1);
            OP_LDA, OP_STA: last_step = 3'd3;
            OP_JC, OP_JZ, OP_LDI, OP_JMP, OP_OUT: last_step = 3'd2;
            default:        last_step = 3'd2;
        endcase
`else
        last_step = 3'(STEPS - 1);
`endif
    end

    // State moves on the falling edge so the control word is settled across the whole high phase.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            step   <= 3'd0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (step == 3'd2 && op == OP_HLT) begin
                halted <= 1'b1;
            end else if (step >= last_step) begin
                step <= 3'd0;
            end else begin
                step <= step + 3'd1;
            end
        end
    end

    // Reset gates the word combinationally so an abort takes effect without a clock edge.
    always_comb begin
        if (!clr) begin
            ctrl_word = IDLE;
        end else if (halted) begin
            ctrl_word = IDLE | HLT;
        end else begin
            ctrl_word = IDLE ^ active;
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the SAP-U 8-bit computer. It takes the 4-bit opcode from the instruction register plus the carry/zero flags. It steps a microstep counter through fetch and execute phases and drives the 16-bit control word that strobes the load/enable ports of every datapath block: PC, MAR, RAM, instruction register, A/B registers, ALU, output register and flags.

## Interface
- `STEPS`, 5: microsteps per instruction (T0..T4); the counter is 3 bits wide.
- `clk` in 1: single system clock.
- `clr` in 1: asynchronous, active-low reset.
- `opcode` in 4: instruction register `q` output.
- `carry` in 1: latched carry flag.
- `zero` in 1: latched zero flag.
- `ctrl_word` out 16: control word; bit map and polarity given below.
- `step` out 3: current microstep, 0..4.
- `halted` out 1: high once HLT has executed.

Control word bits, MSB to LSB:
- 15 HLT; 14 MI_N; 13 RI_N; 12 RO_N; 11 IO_N; 10 II_N; 9 AI_N; 8 AO_N; 7 EO_N; 6 SU; 5 BI_N; 4 OI_N; 3 CE; 2 CO_N; 1 J_N; 0 FI_N.
- `_N` bits are active-low and connect directly to the active-low load/enable ports of the datapath blocks.
- IDLE = 16'h7FB7: no signal asserted.

## Operation
- The control word is combinational from `step`, `opcode`, `carry`, `zero` and `halted`. Any bit not listed for a step holds its IDLE value.
- Fetch, for all opcodes:
  - T0: CO, MI.
  - T1: RO, II, CE.
- Execute, T2..T4:
  - 0001 LDA: T2 IO,MI; T3 RO,AI.
  - 0010 ADD: T2 IO,MI; T3 RO,BI; T4 EO,AI,FI.
  - 0011 SUB: as ADD, with SU also asserted at T4.
  - 0100 STA: T2 IO,MI; T3 AO,RI.
  - 0101 LDI: T2 IO,AI.
  - 0110 JMP: T2 IO,J.
  - 0111 JC: T2 IO,J only if `carry`=1; otherwise IDLE.
  - 1000 JZ: T2 IO,J only if `zero`=1; otherwise IDLE.
  - 1110 OUT: T2 AO,OI.
  - 1111 HLT: T2 HLT.
  - 0000 NOP and all undefined opcodes: IDLE for T2..T4.
- Step counter:
  - Increments modulo STEPS on every falling edge of `clk`.
  - After T4 it wraps to T0.
- HLT:
  - On the falling edge ending an HLT T2, `halted` sets and `step` freezes at 2.
  - While halted, `ctrl_word` = 16'hFFB7.
  - Only `clr` leaves this state.
- While `clr`=0:
  - `step`=0, `halted`=0, and `ctrl_word` is forced to IDLE (16'h7FB7).
  - Asserting reset mid-instruction aborts the instruction immediately; there is no partial-step completion.

## Timing
- State (step counter and halt flag) changes on the falling edge of `clk`. The control word is therefore stable for the entire high phase. Datapath registers sample on the rising edge.
- Latency: a step's control word is valid within combinational delay after the falling edge and is consumed at the following rising edge.
- Flag inputs are sampled combinationally during T2 only. Flag changes in other steps have no effect.
- On `clr` release, the first rising edge sees the T0 word, 16'h3FB3.
- An instruction takes 5 cycles, or fewer with early termination (see Configuration). Instruction length is counted from T0.

## Configuration
- `SEQ_EARLY_RESET_EN` defined: the counter returns to T0 on the falling edge that ends an instruction's last non-IDLE step. This does not apply to HLT.
  - NOP and undefined opcodes, and JC/JZ with the flag false, go to T0 after T2 (3 cycles).
  - LDI, JMP, OUT and JC/JZ taken: 3 cycles. LDA and STA: 4 cycles. ADD and SUB: 5 cycles.
- `SEQ_EARLY_RESET_EN` undefined: every instruction runs all STEPS cycles.

## Test plan
- Reset: hold `clr`=0 across several edges → `ctrl_word`=7FB7, `step`=0, `halted`=0. Release → 3FB3 at T0, 6BBF at T1.
- LDA (`opcode`=0001): T2=37B7, T3=6DB7. With the macro, `step` goes 0,1,2,3,0; without it, T4=7FB7 and then 0.
- SUB (`opcode`=0011): T4=7D76. The counter wraps to T0 after T4 in both builds.
- JC (`opcode`=0111): `carry`=1 → T2=77B5; `carry`=0 → T2=7FB7, and with the macro `step` returns to 0 after T2.
- HLT (`opcode`=1111): after T2, `halted`=1 and `ctrl_word`=FFB7, and `step` stays at 2 for 10 cycles. Pulse `clr` low → 7FB7, then normal fetch.
- Mid-instruction reset: drive `clr` low during ADD T3 → `ctrl_word`=7FB7 asynchronously and `step`=0 without waiting for a clock edge.
